// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The datapath drives the hazard inputs. The sequencer returns per-register stall/flush enables and perf counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_idx;
    logic [4:0]       id_rs2_idx;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd_idx;
    logic             ex_is_load;
    logic             ex_wben;
    logic             ex_is_jump;
    logic             if_valid;
    logic             ls_mem_req;
    logic             ls_mem_ready;
    logic             pc_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             ls_stall;
    logic             id_flush;
    logic             ex_flush;
    logic             wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
        output ex_rd_idx, ex_is_load, ex_wben, ex_is_jump,
        output if_valid, ls_mem_req, ls_mem_ready,
        input  pc_stall, id_stall, ex_stall, ls_stall,
        input  id_flush, ex_flush, wb_flush,
        input  mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
        input  ex_rd_idx, ex_is_load, ex_wben, ex_is_jump,
        input  if_valid, ls_mem_req, ls_mem_ready,
        output pc_stall, id_stall, ex_stall, ls_stall,
        output id_flush, ex_flush, wb_flush,
        output mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It covers load-use, jump flush, LS memory wait, and a timeout halt.
// It also keeps saturating counters of stall cycles and jump flushes.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [2:0] RESP_RESET    = 3'd0;
    localparam logic [2:0] RESP_HALT     = 3'd1;
    localparam logic [2:0] RESP_MEM      = 3'd2;
    localparam logic [2:0] RESP_JUMP     = 3'd3;
    localparam logic [2:0] RESP_LOAD_USE = 3'd4;
    localparam logic [2:0] RESP_FETCH    = 3'd5;
    localparam logic [2:0] RESP_NONE     = 3'd6;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [1:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;
    logic [CNT_W-1:0]  stall_cycles_reg, stall_cycles_next;
    logic [CNT_W-1:0]  flush_events_reg, flush_events_next;

    logic       mem_wait;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic [2:0] resp;
    logic [2:0] stall_depth;
    logic [3:0] stall_vec;
    logic [2:0] flush_vec;

    assign mem_wait = hz.ls_mem_req & ~hz.ls_mem_ready;
    assign rs1_hit  = hz.id_rs1_used & (hz.id_rs1_idx == hz.ex_rd_idx);
    assign rs2_hit  = hz.id_rs2_used & (hz.id_rs2_idx == hz.ex_rd_idx);
    assign load_use = hz.ex_is_load & hz.ex_wben & (hz.ex_rd_idx != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        resp = RESP_NONE;
        if (rst)
            resp = RESP_RESET;
        else if (state_reg == ST_HALT)
            resp = RESP_HALT;
        else if (mem_wait)
            resp = RESP_MEM;
        else if (hz.ex_is_jump)
            resp = RESP_JUMP;
        else if (load_use)
            resp = RESP_LOAD_USE;
        else if (!hz.if_valid)
            resp = RESP_FETCH;
    end

    // Stalls are a depth counted from PC downward. Stage 0=PC, 1=ID, 2=EX, 3=LS. flush_vec is {wb, ex, id}.
    always_comb begin
        stall_depth = 3'd0;
        flush_vec   = 3'b000;
        case (resp)
            RESP_RESET:    flush_vec   = 3'b111;
            RESP_HALT:     stall_depth = 3'd4;
            RESP_MEM: begin
                stall_depth = 3'd4;
                flush_vec   = 3'b100;
            end
            RESP_JUMP:     flush_vec   = 3'b011;
            RESP_LOAD_USE: begin
                stall_depth = 3'd2;
                flush_vec   = 3'b010;
            end
            RESP_FETCH: begin
                stall_depth = 3'd1;
                flush_vec   = 3'b001;
            end
            default: begin
                stall_depth = 3'd0;
                flush_vec   = 3'b000;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stall
            assign stall_vec[gi] = (stall_depth > 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait) begin
                    if (state_reg == ST_RUN) begin
                        state_next    = ST_MEM_WAIT;
                        wait_cnt_next = WAIT_ONE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_next       = ST_HALT;
                        mem_timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                    end
                end else begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // The counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        flush_events_next = flush_events_reg;
        if (stall_vec[0] && stall_cycles_reg != CNT_MAX)
            stall_cycles_next = stall_cycles_reg + CNT_ONE;
        if (resp == RESP_JUMP && flush_events_reg != CNT_MAX)
            flush_events_next = flush_events_reg + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            wait_cnt_reg     <= '0;
            mem_timeout_reg  <= 1'b0;
            stall_cycles_reg <= '0;
            flush_events_reg <= '0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            mem_timeout_reg  <= mem_timeout_next;
            stall_cycles_reg <= stall_cycles_next;
            flush_events_reg <= flush_events_next;
        end
    end

    assign hz.pc_stall     = stall_vec[0];
    assign hz.id_stall     = stall_vec[1];
    assign hz.ex_stall     = stall_vec[2];
    assign hz.ls_stall     = stall_vec[3];
    assign hz.id_flush     = flush_vec[0];
    assign hz.ex_flush     = flush_vec[1];
    assign hz.wb_flush     = flush_vec[2];
    assign hz.mem_timeout  = mem_timeout_reg;
    assign hz.stall_cycles = stall_cycles_reg;
    assign hz.flush_events = flush_events_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl, checked every cycle against a rule-level reference model.
// The design is built with small parameters so that the timeout and counter saturation can be reached.
module tb_pipe_hazard_ctrl;
    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int C_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: current halted flag, consecutive wait cycles and counter values.
    bit m_halt;
    int m_waits;
    int m_stalls;
    int m_flushes;

    always @(negedge clk) begin : model
        bit w, lu, jmp_taken;
        bit e_pc, e_id, e_ex, e_ls, f_id, f_ex, f_wb;
        w  = hz.ls_mem_req && !hz.ls_mem_ready;
        lu = hz.ex_is_load && hz.ex_wben && hz.ex_rd_idx != 0 &&
             ((hz.id_rs1_used && hz.id_rs1_idx == hz.ex_rd_idx) ||
              (hz.id_rs2_used && hz.id_rs2_idx == hz.ex_rd_idx));
        {e_pc, e_id, e_ex, e_ls, f_id, f_ex, f_wb} = '0;
        jmp_taken = 1'b0;
        if (rst) begin
            {f_id, f_ex, f_wb} = 3'b111;
        end else if (m_halt) begin
            {e_pc, e_id, e_ex, e_ls} = 4'b1111;
        end else if (w) begin
            {e_pc, e_id, e_ex, e_ls, f_wb} = 5'b11111;
        end else if (hz.ex_is_jump) begin
            {f_id, f_ex} = 2'b11;
            jmp_taken = 1'b1;
        end else if (lu) begin
            {e_pc, e_id, f_ex} = 3'b111;
        end else if (!hz.if_valid) begin
            {e_pc, f_id} = 2'b11;
        end

        check("pc_stall",     32'(hz.pc_stall),     32'(e_pc));
        check("id_stall",     32'(hz.id_stall),     32'(e_id));
        check("ex_stall",     32'(hz.ex_stall),     32'(e_ex));
        check("ls_stall",     32'(hz.ls_stall),     32'(e_ls));
        check("id_flush",     32'(hz.id_flush),     32'(f_id));
        check("ex_flush",     32'(hz.ex_flush),     32'(f_ex));
        check("wb_flush",     32'(hz.wb_flush),     32'(f_wb));
        check("mem_timeout",  32'(hz.mem_timeout),  32'(m_halt));
        check("stall_cycles", 32'(hz.stall_cycles), 32'(m_stalls));
        check("flush_events", 32'(hz.flush_events), 32'(m_flushes));

        if (rst) begin
            m_halt = 0; m_waits = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (e_pc)      m_stalls  = (m_stalls  >= C_MAX) ? C_MAX : m_stalls + 1;
            if (jmp_taken) m_flushes = (m_flushes >= C_MAX) ? C_MAX : m_flushes + 1;
            if (!m_halt) begin
                if (w) begin
                    m_waits++;
                    if (m_waits >= MT) m_halt = 1;
                end else begin
                    m_waits = 0;
                end
            end
        end
    end

    task automatic idle();
        hz.id_rs1_idx = 5'd0; hz.id_rs2_idx = 5'd0;
        hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_rd_idx = 5'd0; hz.ex_is_load = 1'b0; hz.ex_wben = 1'b0;
        hz.ex_is_jump = 1'b0; hz.if_valid = 1'b1;
        hz.ls_mem_req = 1'b0; hz.ls_mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        hz.ex_is_load = 1'b1; hz.ex_wben = 1'b1; hz.ex_rd_idx = rd;
        hz.id_rs1_idx = rd;   hz.id_rs1_used = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_halt = 0; m_waits = 0; m_stalls = 0; m_flushes = 0;
        rst = 1'b1;
        idle();
        do_reset();

        // Load-use on x5: one stall cycle, then the bubble clears it.
        set_load_use(5'd5);
        tick();
        idle();
        check("lu_stall_cycles", 32'(hz.stall_cycles), 32'd1);
        $display("txn load_use rd=x5 stall_cycles=%0d", hz.stall_cycles);
        tick();

        // rd=x0 and an unused rs2 match must not stall.
        hz.ex_is_load = 1'b1; hz.ex_wben = 1'b1; hz.ex_rd_idx = 5'd0;
        hz.id_rs1_idx = 5'd0; hz.id_rs1_used = 1'b1;
        tick();
        hz.ex_rd_idx = 5'd7; hz.id_rs1_idx = 5'd1; hz.id_rs2_idx = 5'd7; hz.id_rs2_used = 1'b0;
        tick();
        idle();
        check("x0_unused_stall_cycles", 32'(hz.stall_cycles), 32'd1);
        $display("txn x0/unused no-stall stall_cycles=%0d", hz.stall_cycles);

        // A jump together with a load-use: the flush wins.
        do_reset();
        set_load_use(5'd9);
        hz.ex_is_jump = 1'b1;
        #2;
        check("jump_lu_pc_stall", 32'(hz.pc_stall), 32'd0);
        tick();
        idle();
        check("jump_lu_flush_events", 32'(hz.flush_events), 32'd1);
        $display("txn jump+load_use flush_events=%0d", hz.flush_events);

        // A 3-cycle memory wait with a pending jump. The jump fires in the ready cycle.
        do_reset();
        hz.ls_mem_req = 1'b1; hz.ex_is_jump = 1'b1;
        repeat (3) tick();
        hz.ls_mem_ready = 1'b1;
        #2;
        check("memwait_jump_id_flush", 32'(hz.id_flush), 32'd1);
        tick();
        idle();
        check("memwait_flush_events", 32'(hz.flush_events), 32'd1);
        check("memwait_stall_cycles", 32'(hz.stall_cycles), 32'd3);
        $display("txn mem_wait x3 + jump stalls=%0d flushes=%0d", hz.stall_cycles, hz.flush_events);

        // Timeout: ready is never asserted, so the pipe halts after MT wait cycles.
        do_reset();
        hz.ls_mem_req = 1'b1;
        repeat (MT) tick();
        idle();
        check("timeout_flag", 32'(hz.mem_timeout), 32'd1);
        check("timeout_ls_stall", 32'(hz.ls_stall), 32'd1);
        tick();
        do_reset();
        check("timeout_cleared", 32'(hz.mem_timeout), 32'd0);
        $display("txn mem_timeout halt and reset recovery");

        // Saturation: 20 load-use cycles against a 4-bit counter.
        do_reset();
        set_load_use(5'd3);
        repeat (20) tick();
        idle();
        check("sat_stall_cycles", 32'(hz.stall_cycles), 32'd15);
        $display("txn 20 load-use stalls stall_cycles=%0d", hz.stall_cycles);

        // Random traffic. The ready probability changes between phases so that timeouts and halts also occur.
        for (int ph = 0; ph < 12; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 2) ? 3 : 60;
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 99) == 0);
                hz.id_rs1_idx   = 5'($urandom_range(0, 3));
                hz.id_rs2_idx   = 5'($urandom_range(0, 3));
                hz.id_rs1_used  = 1'($urandom_range(0, 1));
                hz.id_rs2_used  = 1'($urandom_range(0, 1));
                hz.ex_rd_idx    = 5'($urandom_range(0, 3));
                hz.ex_is_load   = ($urandom_range(0, 99) < 40);
                hz.ex_wben      = ($urandom_range(0, 99) < 80);
                hz.ex_is_jump   = ($urandom_range(0, 99) < 15);
                hz.if_valid     = ($urandom_range(0, 99) < 80);
                hz.ls_mem_req   = ($urandom_range(0, 99) < 40);
                hz.ls_mem_ready = ($urandom_range(0, 99) < rdy_pct);
                tick();
            end
            $display("txn random phase %0d ready_pct=%0d", ph, rdy_pct);
        end
        rst = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
